// File: rtl/branch_resolver_if.sv
// Branch-resolution bus between the control unit (master) and branch_resolver (slave).
interface branch_resolver_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              uncond;
    logic [ADDR_W-1:0] pc_in;
    logic [15:0]       offset;
    logic              cond_in;
    logic              clear_counts;
    logic              busy;
    logic              done;
    logic              taken;
    logic              pc_write;
    logic [ADDR_W-1:0] pc_target;
    logic [CNT_W-1:0]  taken_count;
    logic [CNT_W-1:0]  total_count;

    modport master (
        output start, uncond, pc_in, offset, cond_in, clear_counts,
        input  busy, done, taken, pc_write, pc_target, taken_count, total_count
    );

    modport slave (
        input  start, uncond, pc_in, offset, cond_in, clear_counts,
        output busy, done, taken, pc_write, pc_target, taken_count, total_count
    );
endinterface

// File: rtl/branch_resolver.sv
// Multicycle branch resolver: latches branch context, computes the target, samples the
// selected condition, pulses a PC write when taken and keeps saturating statistics.
module branch_resolver #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    branch_resolver_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_EVAL  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       offset_q, offset_d;
    logic              uncond_q, uncond_d;
    logic              taken_q, taken_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic [CNT_W-1:0]  ncnt_q, ncnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pc_write_q, pc_write_d;
    logic              eval_t_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Next-state, datapath and Moore output decode
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        offset_d   = offset_q;
        uncond_d   = uncond_q;
        taken_d    = taken_q;
        target_d   = target_q;
        tcnt_d     = tcnt_q;
        ncnt_d     = ncnt_q;
        eval_t_s   = uncond_q | bus.cond_in;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pc_d     = bus.pc_in;
                    offset_d = bus.offset;
                    uncond_d = bus.uncond;
                    taken_d  = 1'b0;
                    state_d  = S_CALC;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CALC: begin
                // Word offset: sign-extend then scale by 4; wrap-around is intended.
                target_d = pc_q + {{(ADDR_W-18){offset_q[15]}}, offset_q, 2'b00};
                state_d  = S_EVAL;
            end
            S_EVAL: begin
                taken_d = eval_t_s;
                ncnt_d  = sat_inc(ncnt_q);
                if (eval_t_s) begin
                    tcnt_d  = sat_inc(tcnt_q);
                    state_d = S_WRITE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A clear beats a same-cycle increment.
        if (bus.clear_counts) begin
            tcnt_d = {CNT_W{1'b0}};
            ncnt_d = {CNT_W{1'b0}};
        end else begin
            tcnt_d = tcnt_d;
            ncnt_d = ncnt_d;
        end

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        pc_write_d = (state_d == S_WRITE);
    end

    // State and registered output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= {ADDR_W{1'b0}};
            offset_q   <= 16'h0000;
            uncond_q   <= 1'b0;
            taken_q    <= 1'b0;
            target_q   <= {ADDR_W{1'b0}};
            tcnt_q     <= {CNT_W{1'b0}};
            ncnt_q     <= {CNT_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pc_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            offset_q   <= offset_d;
            uncond_q   <= uncond_d;
            taken_q    <= taken_d;
            target_q   <= target_d;
            tcnt_q     <= tcnt_d;
            ncnt_q     <= ncnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pc_write_q <= pc_write_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pc_write    = pc_write_q;
    assign bus.taken       = taken_q;
    assign bus.pc_target   = target_q;
    assign bus.taken_count = tcnt_q;
    assign bus.total_count = ncnt_q;

endmodule
